pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised N-bit adder/subtractor built as a ripple-carry chain, split into STAGES register-separated segments.
- Each segment adds WIDTH/STAGES bits. The carry is registered between segments, so the clock period depends on the segment width rather than on WIDTH.
- Uses a valid/ready handshake on both sides and accepts one operation per cycle.
- Datapath building block placed between operand sources and result consumers; it is the successor to the single-bit full adder.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be >= 1.
- STAGES, 4, number of pipeline segments; must be in 1..WIDTH and divide WIDTH exactly. An illegal value is an elaboration-time error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  operand A, unsigned two's-complement bit vector
- b  input  WIDTH  operand B
- cin  input  1  carry-in; ignored when sub=1
- sub  input  1  0: a+b+cin; 1: a-b
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result bits
- cout  output  1  carry-out of the MSB; for subtraction this is the no-borrow flag (1 when a>=b unsigned)

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Subtraction: sub=1 computes a + ~b + 1. The inverted b and the forced carry-in are applied at entry, before stage 0.
- Stage k, for k = 0..STAGES-1:
  - Adds bit slice [(k+1)*W/S-1 : k*W/S] of a and b(') with the carry registered from stage k-1; stage 0 uses the entry carry.
  - Stores its slice of sum and its carry-out.
  - Operand slices not yet consumed travel alongside in pipeline registers.
- Latency: exactly STAGES cycles from input transfer to out_valid, with no stall.
  - STAGES=1 gives one registered stage.
- Throughput: one operation per cycle while out_ready=1.
- Stall rule:
  - advance = !out_valid || out_ready.
  - When advance=0, every stage register and every valid bit holds its value.
  - When advance=1, all stages shift by one.
- in_ready = advance. This is combinational from out_ready; there is no in_valid -> in_ready path.
- Bubbles: a valid bit is carried per stage. Bubbles propagate, and a bubble ahead of a stalled output is not compressed (simple global stall).
- Ordering: strictly in order. Results appear in acceptance order with no loss or duplication.
- Output stability: sum and cout are held stable while out_valid=1 && out_ready=0.
- Wrap-around: the sum is modulo 2^WIDTH. The overflowed bit appears only on cout.
- Reset:
  - rst=1 at a clock edge clears all valid bits, sum and cout to 0 and stage data to 0.
  - Operations in flight are discarded; no partial result is ever emitted.
  - in_ready=1 in the first cycle after reset deasserts.
- Simultaneous events:
  - rst has priority over any transfer.
  - In the same cycle as an output transfer, a new input may be accepted; the pipeline shifts.
- in_valid=0 with advance=1 inserts a bubble.

Optional Feature:
- Macro: PIPELINED_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered and aligned with sum/out_valid.
  - ovf = signed two's-complement overflow: carry into MSB XOR carry out of MSB, with subtraction accounted for via the inverted b.
  - Reset value 0. Held under stall like sum.
- Undefined: ovf port is absent; there is no extra logic.

Test Plan:
- WIDTH=8, STAGES=2:
  - a=0xFF, b=0x01, cin=0, sub=0, out_ready=1 -> out_valid exactly 2 cycles later; sum=0x00, cout=1.
  - a=0x05, b=0x07, sub=1, cin=1 (ignored) -> sum=0xFE, cout=0.
  - a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.
- Back-to-back: 8 consecutive ops (a=i, b=2i, i=0..7), out_ready=1 -> 8 results on 8 consecutive cycles; sum=3i, in order.
- Backpressure: out_ready=0 for 5 cycles with pipeline full:
  - in_ready=0 and sum/cout held constant.
  - After out_ready=1, all results are delivered with none lost or duplicated.
- Reset mid-flight: accept 2 ops, assert rst for 1 cycle -> out_valid=0, sum=0, cout=0 next cycle; no stale result ever appears.
- With PIPELINED_ADDER_OVF_EN defined, WIDTH=8:
  - a=0x7F, b=0x01, sub=0 -> sum=0x80, ovf=1, cout=0.
  - a=0x80, b=0x01, sub=1 -> sum=0x7F, ovf=1.
- WIDTH=32, STAGES=4 random soak: 10k ops with random in_valid/out_ready -> every sum/cout matches a scoreboard built on a+b+cin, or a-b, modulo 2^32.

Source files
------------

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The ovf signal exists only when PIPELINED_ADDER_OVF_EN is defined.
interface pipelined_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef PIPELINED_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: STAGES segments of WIDTH/STAGES bits with the carry
// registered between segments. Define PIPELINED_ADDER_OVF_EN for the registered signed-overflow ovf.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input logic              clk,
  input logic              rst,
  pipelined_adder_if.slave bus
);

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_adder: STAGES must lie in 1..WIDTH and divide WIDTH exactly");
  end

  localparam int unsigned SegW = WIDTH / STAGES;

  // Per-stage registers; bits of sum above the finished slices are still zero.
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;

  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  s_in [STAGES];
  logic [WIDTH-1:0]  s_d  [STAGES];
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] c_d;
  logic [STAGES-1:0] v_in;
  logic [SegW:0]     seg;
  logic              advance;

  // Global stall: a bubble in front of a blocked output is not squeezed out.
  assign advance      = !v_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready = advance;

  always_comb begin
    // Subtraction becomes a + ~b + 1 before the first segment.
    a_in[0] = bus.a;
    b_in[0] = bus.sub ? ~bus.b : bus.b;
    s_in[0] = '0;
    c_in[0] = bus.sub | bus.cin;
    v_in[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
    end
    seg = '0;
    for (int k = 0; k < STAGES; k++) begin
      seg = {1'b0, a_in[k][k*SegW +: SegW]} + {1'b0, b_in[k][k*SegW +: SegW]}
          + {{SegW{1'b0}}, c_in[k]};
      s_d[k] = s_in[k];
      s_d[k][k*SegW +: SegW] = seg[SegW-1:0];
      c_d[k] = seg[SegW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q <= '0;
      v_q <= '0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        s_q[k] <= s_d[k];
      end
      c_q <= c_d;
      v_q <= v_in;
    end
  end

  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = s_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];

`ifdef PIPELINED_ADDER_OVF_EN
  logic ovf_q;

  // Carry into the MSB is a^b^sum at that bit; b is already inverted for subtraction.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1]
             ^ s_d[STAGES-1][WIDTH-1] ^ c_d[STAGES-1];
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed 8-bit/2-stage checks plus a 32-bit/4-stage
// random soak, both scored against a queue-based reference model.
module tb_pipelined_adder;

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [31:0] sum;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(8))  bus8 ();
  pipelined_adder_if #(.WIDTH(32)) bus32 ();

  pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  int   got32       = 0;
  res_t q8 [$];
  res_t q32 [$];
  res_t e8;
  res_t e32;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned add/subtract with a>=b no-borrow flag, signed range test for ovf.
  function automatic res_t model(input int w, input longint unsigned a, input longint unsigned b,
                                 input bit cin, input bit sub);
    res_t              r;
    longint unsigned   full;
    longint unsigned   mask;
    longint            lim;
    longint            sa;
    longint            sb;
    longint            sr;
    mask = (64'd1 << w) - 64'd1;
    if (sub) begin
      full   = a - b;
      r.cout = (a >= b);
    end else begin
      full   = a + b + longint'(cin);
      r.cout = full[w];
    end
    r.sum = 32'(full & mask);
    lim   = 64'sd1 <<< (w - 1);
    sa    = longint'(a);
    sb    = longint'(b);
    if (a[w-1]) sa = sa - 2 * lim;
    if (b[w-1]) sb = sb - 2 * lim;
    sr    = sub ? sa - sb : sa + sb + longint'(cin);
    r.ovf = (sr >= lim) || (sr < -lim);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q8.delete();
    end else begin
      if (bus8.out_valid && bus8.out_ready) begin
        check("sb8_nonempty", 64'(q8.size() != 0), 1);
        if (q8.size() != 0) begin
          e8 = q8.pop_front();
          check("sb8_sum", bus8.sum, 64'(e8.sum[7:0]));
          check("sb8_cout", bus8.cout, e8.cout);
`ifdef PIPELINED_ADDER_OVF_EN
          check("sb8_ovf", bus8.ovf, e8.ovf);
`endif
        end
      end
      if (bus8.in_valid && bus8.in_ready) q8.push_back(model(8, bus8.a, bus8.b, bus8.cin, bus8.sub));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q32.delete();
    end else begin
      if (bus32.out_valid && bus32.out_ready) begin
        got32++;
        check("sb32_nonempty", 64'(q32.size() != 0), 1);
        if (q32.size() != 0) begin
          e32 = q32.pop_front();
          check("sb32_sum", bus32.sum, e32.sum);
          check("sb32_cout", bus32.cout, e32.cout);
`ifdef PIPELINED_ADDER_OVF_EN
          check("sb32_ovf", bus32.ovf, e32.ovf);
`endif
        end
      end
      if (bus32.in_valid && bus32.in_ready)
        q32.push_back(model(32, bus32.a, bus32.b, bus32.cin, bus32.sub));
    end
  end

  // One isolated op on the 8-bit unit: idle for two cycles, valid on the third.
  task automatic single8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sub, input logic [7:0] es, input logic ec);
    @(posedge clk); #1;
    bus8.in_valid = 1'b1;
    bus8.a = a;
    bus8.b = b;
    bus8.cin = cin;
    bus8.sub = sub;
    @(negedge clk);
    check("lat_c0_idle", bus8.out_valid, 0);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    @(negedge clk);
    check("lat_c1_idle", bus8.out_valid, 0);
    @(negedge clk);
    check("lat_c2_valid", bus8.out_valid, 1);
    check("single_sum", bus8.sum, 64'(es));
    check("single_cout", bus8.cout, ec);
  endtask

  bit acc;
  int sent;

  initial begin
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.cin       = 1'b0;
    bus8.sub       = 1'b0;
    bus8.out_ready = 1'b1;
    bus32.in_valid  = 1'b0;
    bus32.a         = '0;
    bus32.b         = '0;
    bus32.cin       = 1'b0;
    bus32.sub       = 1'b0;
    bus32.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid8", bus8.out_valid, 0);
    check("rst_sum8", bus8.sum, 0);
    check("rst_cout8", bus8.cout, 0);
    check("rst_ready8", bus8.in_ready, 1);
    check("rst_valid32", bus32.out_valid, 0);
    check("rst_sum32", bus32.sum, 0);
    check("rst_ready32", bus32.in_ready, 1);
`ifdef PIPELINED_ADDER_OVF_EN
    check("rst_ovf8", bus8.ovf, 0);
`endif

    single8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    single8(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0);
    single8(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1);
`ifdef PIPELINED_ADDER_OVF_EN
    single8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0);
    check("ovf_add", bus8.ovf, 1);
    single8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1);
    check("ovf_sub", bus8.ovf, 1);
`endif

    // Back-to-back: eight ops, results on eight consecutive cycles.
    @(posedge clk); #1;
    for (int j = 0; j < 10; j++) begin
      if (j < 8) begin
        bus8.in_valid = 1'b1;
        bus8.a   = 8'(j);
        bus8.b   = 8'(2 * j);
        bus8.cin = 1'b0;
        bus8.sub = 1'b0;
      end else begin
        bus8.in_valid = 1'b0;
      end
      @(negedge clk);
      if (j >= 2) begin
        check("b2b_valid", bus8.out_valid, 1);
        check("b2b_sum", bus8.sum, 64'(3 * (j - 2)));
      end else begin
        check("b2b_fill", bus8.out_valid, 0);
      end
      @(posedge clk); #1;
    end

    // Backpressure: fill with out_ready low, hold five cycles, then drain.
    bus8.out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      bus8.in_valid = 1'b1;
      bus8.a   = 8'(8'hF0 + j);
      bus8.b   = 8'h20;
      bus8.cin = 1'b0;
      bus8.sub = 1'b0;
      if (j < 2) begin
        @(posedge clk); #1;
      end
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("stall_in_ready", bus8.in_ready, 0);
      check("stall_valid", bus8.out_valid, 1);
      check("stall_sum", bus8.sum, 64'h10);
      check("stall_cout", bus8.cout, 1);
      @(posedge clk); #1;
    end
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stall_drain", 64'(q8.size()), 0);

    // Reset with two ops in flight.
    bus8.out_ready = 1'b0;
    bus8.in_valid = 1'b1;
    bus8.a = 8'h11;
    bus8.b = 8'h22;
    @(posedge clk); #1;
    bus8.a = 8'h33;
    bus8.b = 8'h44;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", bus8.out_valid, 0);
    check("mid_rst_sum", bus8.sum, 0);
    check("mid_rst_cout", bus8.cout, 0);
    check("mid_rst_ready", bus8.in_ready, 1);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("mid_rst_no_stale", bus8.out_valid, 0);
    end

    // 32-bit random soak with random valid/ready; inputs held until accepted.
    sent = 0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 40000 && sent < 10000; cyc++) begin
      @(negedge clk);
      acc = bus32.in_valid && bus32.in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      if (acc || !bus32.in_valid) begin
        bus32.in_valid = ($urandom_range(3) != 0);
        bus32.a   = $urandom();
        bus32.b   = $urandom();
        bus32.cin = 1'($urandom_range(1));
        bus32.sub = 1'($urandom_range(1));
      end
      bus32.out_ready = ($urandom_range(3) != 0);
    end
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    for (int j = 0; j < 20 && q32.size() != 0; j++) @(negedge clk);
    check("soak_sent", 64'(sent), 10000);
    check("soak_drain", 64'(q32.size()), 0);
    check("soak_received", 64'(got32), 10000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
